// File: rtl/jc_gate_counter_pkg.sv
// Shared constants for the Johnson-code gate counter: phase table,
// BCD digit limit, count width, and the Johnson decode helper.
package jc_gate_counter_pkg;

  localparam int         CNT_W     = 8;
  localparam logic [3:0] DIGIT_MAX = 4'h9;

  localparam logic [3:0] JC_P0 = 4'b0000;
  localparam logic [3:0] JC_P1 = 4'b0001;
  localparam logic [3:0] JC_P2 = 4'b0011;
  localparam logic [3:0] JC_P3 = 4'b0111;
  localparam logic [3:0] JC_P4 = 4'b1111;
  localparam logic [3:0] JC_P5 = 4'b1110;
  localparam logic [3:0] JC_P6 = 4'b1100;
  localparam logic [3:0] JC_P7 = 4'b1000;

  typedef struct packed {
    logic       valid;
    logic [2:0] ph;
  } jc_dec_t;

  function automatic jc_dec_t jc_decode(input logic [3:0] code);
    jc_dec_t d;
    d = '{valid: 1'b0, ph: 3'd0};
    case (code)
      JC_P0: d = '{valid: 1'b1, ph: 3'd0};
      JC_P1: d = '{valid: 1'b1, ph: 3'd1};
      JC_P2: d = '{valid: 1'b1, ph: 3'd2};
      JC_P3: d = '{valid: 1'b1, ph: 3'd3};
      JC_P4: d = '{valid: 1'b1, ph: 3'd4};
      JC_P5: d = '{valid: 1'b1, ph: 3'd5};
      JC_P6: d = '{valid: 1'b1, ph: 3'd6};
      JC_P7: d = '{valid: 1'b1, ph: 3'd7};
      default: d = '{valid: 1'b0, ph: 3'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jc_gate_counter_bcd_digit.sv
// One BCD digit: count enable, synchronous clear with optional
// load-of-one, and a combinational carry-out at digit maximum.
module bcd_digit
  import jc_gate_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       ld1_i,
  output logic [3:0] q_o,
  output logic       co_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = ld1_i ? 4'd1 : 4'd0;
    end else if (en_i) begin
      q_d = (q_q == DIGIT_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  assign q_o  = q_q;
  assign co_o = en_i & (q_q == DIGIT_MAX);

endmodule

// File: rtl/jc_gate_counter.sv
// Two-digit BCD gate counter fed by a Johnson counter cascade.
// Define JC_CODE_CHECK_EN to hold ph and flag err on illegal jq codes.
module jc_gate_counter
  import jc_gate_counter_pkg::*;
(
  input  logic             clk,
  input  logic             R,
  input  logic             ce,
  input  logic [3:0]       jq,
  input  logic             lat,
  output logic [2:0]       ph,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] dsp,
  output logic             ovf,
  output logic             err,
  output logic             CEO
);

  logic       units_co;
  logic       tens_co;
  logic [3:0] units_q;
  logic [3:0] tens_q;

  // lat with ce restarts the gate already holding this cycle's pulse
  bcd_digit u_units (
    .clk   (clk),
    .rst   (R),
    .en_i  (ce),
    .clr_i (lat),
    .ld1_i (ce),
    .q_o   (units_q),
    .co_o  (units_co)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (R),
    .en_i  (units_co),
    .clr_i (lat),
    .ld1_i (1'b0),
    .q_o   (tens_q),
    .co_o  (tens_co)
  );

  assign cnt = {tens_q, units_q};

  logic [2:0]       ph_q, ph_d;
  logic [CNT_W-1:0] dsp_q, dsp_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  jc_dec_t          dec;

  always_comb begin
    dec   = jc_decode(jq);
    dsp_d = lat ? cnt : dsp_q;
    ovf_d = ovf_q;
    if (lat)          ovf_d = 1'b0;
    else if (tens_co) ovf_d = 1'b1;
`ifdef JC_CODE_CHECK_EN
    ph_d  = dec.valid ? dec.ph : ph_q;
    err_d = err_q | ~dec.valid;
`else
    ph_d  = dec.ph;
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ph_q  <= 3'd0;
      dsp_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      dsp_q <= dsp_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign ph  = ph_q;
  assign dsp = dsp_q;
  assign ovf = ovf_q;
  assign err = err_q;
  assign CEO = tens_co & ~lat & ~R;

endmodule

// File: tb/tb_jc_gate_counter.sv
// Directed self-checking bench for jc_gate_counter.
module tb_jc_gate_counter;

  logic       clk = 1'b0;
  logic       R   = 1'b1;
  logic       ce  = 1'b0;
  logic [3:0] jq  = 4'b0000;
  logic       lat = 1'b0;
  logic [2:0] ph;
  logic [7:0] cnt;
  logic [7:0] dsp;
  logic       ovf;
  logic       err;
  logic       CEO;

  int vectors = 0;
  int miscompares = 0;

  jc_gate_counter dut (
    .clk (clk),
    .R   (R),
    .ce  (ce),
    .jq  (jq),
    .lat (lat),
    .ph  (ph),
    .cnt (cnt),
    .dsp (dsp),
    .ovf (ovf),
    .err (err),
    .CEO (CEO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ce  = 1'b0;
    lat = 1'b0;
    R   = 1'b1;
    #3;
    R   = 1'b0;
  endtask

  task automatic test_reset();
    R  = 1'b1;
    ce = 1'b1;
    jq = 4'b1111;
    #20;
    vectors++;
    if ({ph, cnt, dsp, ovf, err, CEO} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outs got ph=%0d cnt=%h dsp=%h ovf=%b err=%b CEO=%b want all 0",
               ph, cnt, dsp, ovf, err, CEO);
    end
    @(posedge clk);
    #1;
    R = 1'b0;
    tick();
    ce = 1'b0;
    vectors++;
    if (ph !== 3'd4) begin
      miscompares++;
      $display("FAIL reset_ph4 got %0d want 4", ph);
    end
    vectors++;
    if (cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_resume got %h want 01", cnt);
    end
  endtask

  task automatic test_phase();
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
              4'b1111, 4'b1110, 4'b1100, 4'b1000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      jq = codes[i];
      tick();
      vectors++;
      if (ph !== 3'(i) || err !== 1'b0) begin
        miscompares++;
        $display("FAIL phase_%0d got ph=%0d err=%b want ph=%0d err=0",
                 i, ph, err, i);
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    ce = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k == 98 || k == 99) begin
        vectors++;
        if (CEO !== (k == 99) || ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL ceo_at_%0d got CEO=%b ovf=%b want CEO=%b ovf=0",
                   k, CEO, ovf, (k == 99));
        end
      end
      tick();
      if (k == 9) begin
        vectors++;
        if (cnt !== 8'h10) begin
          miscompares++;
          $display("FAIL carry_09_10 got %h want 10", cnt);
        end
      end
    end
    ce = 1'b0;
    vectors++;
    if (cnt !== 8'h00 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap got cnt=%h ovf=%b want 00/1", cnt, ovf);
    end
    tick();
    tick();
    vectors++;
    if (cnt !== 8'h00 || ovf !== 1'b1 || dsp !== 8'h00) begin
      miscompares++;
      $display("FAIL hold got cnt=%h ovf=%b dsp=%h want 00/1/00",
               cnt, ovf, dsp);
    end
    ce = 1'b1;
    tick();
    tick();
    tick();
    ce  = 1'b0;
    lat = 1'b1;
    tick();
    lat = 1'b0;
    vectors++;
    if (dsp !== 8'h03 || cnt !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_clr_ovf got dsp=%h cnt=%h ovf=%b want 03/00/0",
               dsp, cnt, ovf);
    end
  endtask

  task automatic test_latch();
    do_reset();
    ce = 1'b1;
    repeat (42) tick();
    ce = 1'b0;
    vectors++;
    if (cnt !== 8'h42) begin
      miscompares++;
      $display("FAIL cnt42 got %h want 42", cnt);
    end
    lat = 1'b1;
    tick();
    lat = 1'b0;
    vectors++;
    if (dsp !== 8'h42 || cnt !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_ce0 got dsp=%h cnt=%h ovf=%b want 42/00/0",
               dsp, cnt, ovf);
    end
    ce = 1'b1;
    repeat (42) tick();
    lat = 1'b1;
    tick();
    lat = 1'b0;
    ce  = 1'b0;
    vectors++;
    if (dsp !== 8'h42 || cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL lat_ce1 got dsp=%h cnt=%h want 42/01", dsp, cnt);
    end
    ce = 1'b1;
    repeat (98) tick();
    lat = 1'b1;
    #1;
    vectors++;
    if (cnt !== 8'h99 || CEO !== 1'b0) begin
      miscompares++;
      $display("FAIL ceo_lat99 got cnt=%h CEO=%b want 99/0", cnt, CEO);
    end
    tick();
    lat = 1'b0;
    ce  = 1'b0;
    vectors++;
    if (dsp !== 8'h99 || cnt !== 8'h01 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_ce1_99 got dsp=%h cnt=%h ovf=%b want 99/01/0",
               dsp, cnt, ovf);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] exp_ph;
    logic       exp_err;
`ifdef JC_CODE_CHECK_EN
    exp_ph  = 3'd3;
    exp_err = 1'b1;
`else
    exp_ph  = 3'd0;
    exp_err = 1'b0;
`endif
    do_reset();
    jq = 4'b0111;
    tick();
    vectors++;
    if (ph !== 3'd3) begin
      miscompares++;
      $display("FAIL ill_pre got ph=%0d want 3", ph);
    end
    jq = 4'b0101;
    tick();
    jq = 4'b0111;
    vectors++;
    if (ph !== exp_ph || err !== exp_err) begin
      miscompares++;
      $display("FAIL ill_code got ph=%0d err=%b want %0d/%b",
               ph, err, exp_ph, exp_err);
    end
    lat = 1'b1;
    tick();
    lat = 1'b0;
    vectors++;
    if (err !== exp_err || ph !== 3'd3) begin
      miscompares++;
      $display("FAIL ill_lat got err=%b ph=%0d want %b/3", err, ph, exp_err);
    end
    R = 1'b1;
    #2;
    vectors++;
    if (err !== 1'b0 || ph !== 3'd0) begin
      miscompares++;
      $display("FAIL ill_rst got err=%b ph=%0d want 0/0", err, ph);
    end
    R = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ce = 1'b1;
    repeat (57) tick();
    ce = 1'b0;
    vectors++;
    if (cnt !== 8'h57) begin
      miscompares++;
      $display("FAIL cnt57 got %h want 57", cnt);
    end
    #3;
    R = 1'b1;
    #1;
    vectors++;
    if (cnt !== 8'h00 || CEO !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got cnt=%h CEO=%b want 00/0", cnt, CEO);
    end
    ce = 1'b1;
    #1;
    vectors++;
    if (CEO !== 1'b0) begin
      miscompares++;
      $display("FAIL ceo_in_rst got %b want 0", CEO);
    end
    ce = 1'b0;
    tick();
    R = 1'b0;
    repeat (3) tick();
    vectors++;
    if (cnt !== 8'h00 || dsp !== 8'h00 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ce0_hold got cnt=%h dsp=%h ovf=%b want 00/00/0",
               cnt, dsp, ovf);
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
    vectors++;
    if (cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL resume got %h want 01", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_count_wrap();
    test_latch();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jc_gate_counter.md
JC_GATE_COUNTER -- requirements
Module: jc_gate_counter

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 R  in  1  reset, asynchronous, active-high; clears all state immediately on assertion, independent of clk.
REQ-003 ce  in  1  count enable, driven by upstream Johnson counter CEO; one pulse per upstream full cycle.
REQ-004 jq  in  4  upstream Johnson counter Q[3:0].
REQ-005 lat  in  1  gate strobe, one clk wide; latches count to display and restarts gate.
REQ-006 ph  out  3  registered phase index decoded from jq.
REQ-007 cnt  out  8  live two-digit BCD count; [7:4] tens, [3:0] units.
REQ-008 dsp  out  8  latched BCD count from the last lat.
REQ-009 ovf  out  1  sticky flag: cnt wrapped 99->00 since last lat or reset.
REQ-010 err  out  1  sticky flag: illegal Johnson code seen on jq.
REQ-011 CEO  out  1  cascade carry, combinational = ce & (cnt==8'h99) & ~lat.

Function
REQ-012 Valid jq codes map to ph: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
REQ-013 ph updates one clk after jq changes; latency exactly 1 cycle.
REQ-014 Illegal jq code (other 8 values): ph holds previous value.
REQ-015 ce=1, lat=0: cnt increments by 1 in BCD; units 9->0 carries to tens; 99->00 wraps.
REQ-016 Wrap 99->00 sets ovf on the same edge; ovf stays 1 until lat or R.
REQ-017 ce=0, lat=0: cnt, dsp, ovf hold.
REQ-018 lat=1, ce=0: dsp<=cnt, cnt<=00, ovf<=0 on the same edge.
REQ-019 lat=1, ce=1 simultaneously: dsp<=old cnt (pre-increment), cnt<=01, ovf<=0; CEO=0 even at cnt=99.
REQ-020 cnt digits never leave 0..9; no non-BCD nibble is reachable from reset.
REQ-021 err is not cleared by lat; only R clears it.

Reset
REQ-022 R=1: ph=0, cnt=00, dsp=00, ovf=0, err=0 immediately and held while R=1.
REQ-023 R deasserted mid-count: counting resumes from 00 on the first rising clk with ce=1.
REQ-024 CEO=0 while R=1 regardless of ce.

Configuration
REQ-025 Macro JC_CODE_CHECK_EN defined: illegal-code detection per REQ-010/014/021 is compiled in.
REQ-026 JC_CODE_CHECK_EN undefined: err tied to 0; illegal jq codes decode to ph=0; all other behaviour unchanged.

Structure
REQ-027 Shared package holds the Johnson-code-to-phase table constants, the BCD digit-maximum constant (4'h9), and the count width (8).
REQ-028 One sub-module, bcd_digit: 4-bit BCD digit with enable, clear, load-one, and carry-out; jc_gate_counter instantiates two in cascade.
REQ-029 Top level holds the jq decode register, dsp/ovf/err registers, and CEO logic.

Verification
REQ-030 R=1 for 20 ns with ce=1 and jq=1111 -> all outputs 0 during R; after release, ph=4 one clk later.
REQ-031 Step jq through the 8 valid codes, one per clk -> ph=0..7 each lagging 1 clk; err stays 0.
REQ-032 ce=1 for 100 clks from reset -> cnt=00 with ovf=1; CEO=1 in the cycle cnt=99; cnt=09->10 carry checked.
REQ-033 cnt=42, pulse lat with ce=0 -> dsp=42, cnt=00, ovf=0; repeat with ce=1 -> dsp=42, cnt=01.
REQ-034 jq=0101 for 1 clk after ph=3 -> err=1 and ph stays 3 (with macro); without macro: err=0, ph=0; err survives lat, clears on R.
REQ-035 R asserted mid-clock-period at cnt=57 -> cnt=00 before the next edge; ce=0 pulses -> no change.
